// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: standard mode
// geometries, TMDS control symbols and the segment-total helper.
package video_timing_pkg;

    // One raster mode: four horizontal and four vertical segment lengths
    // plus the asserted sync levels.
    typedef struct packed {
        logic [11:0] h_active;
        logic [11:0] h_fp;
        logic [11:0] h_sync;
        logic [11:0] h_bp;
        logic [11:0] v_active;
        logic [11:0] v_fp;
        logic [11:0] v_sync;
        logic [11:0] v_bp;
        logic        hsync_pol;
        logic        vsync_pol;
    } mode_t;

    // 640x480@60, 25.175 MHz, both syncs active-low.
    localparam mode_t MODE_640X480_60 = '{
        12'd640, 12'd16, 12'd96, 12'd48,
        12'd480, 12'd10, 12'd2,  12'd33,
        1'b0, 1'b0
    };

    // 800x600@60, 40 MHz, both syncs active-high.
    localparam mode_t MODE_800X600_60 = '{
        12'd800, 12'd40, 12'd128, 12'd88,
        12'd600, 12'd1,  12'd4,   12'd23,
        1'b1, 1'b1
    };

    // 1280x720@60, 74.25 MHz, both syncs active-high (needs COORD_W >= 11).
    localparam mode_t MODE_1280X720_60 = '{
        12'd1280, 12'd110, 12'd40, 12'd220,
        12'd720,  12'd5,   12'd5,  12'd20,
        1'b1, 1'b1
    };

    // TMDS control symbols, indexed by {vsync,hsync} during blanking.
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // Period of one axis from its four segment lengths.
    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: a wrapping position counter plus decodes of the
// position it will hold after this cycle, so the parent can register
// its outputs in step with the counter.
module timing_axis #(
    parameter int W         = 10,
    parameter int TOTAL     = 800,
    parameter int ACTIVE    = 640,
    parameter int WIN_START = 656,
    parameter int WIN_LEN   = 96
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_nxt,
    output logic         o_wrap,
    output logic         o_nxt_act,
    output logic         o_nxt_win
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    // Decodes use one extra bit so START+LEN cannot overflow.
    localparam logic [W:0]   C_ACT = (W+1)'(ACTIVE);
    localparam logic [W:0]   C_WS  = (W+1)'(WIN_START);
    localparam logic [W:0]   C_WE  = (W+1)'(WIN_START + WIN_LEN);

    logic [W-1:0] r_cnt;
    logic         w_at_end;
    logic [W:0]   w_nxt_e;

    assign w_at_end = (r_cnt == LAST);
    assign o_wrap   = i_inc && w_at_end;
    assign o_cnt    = r_cnt;
    assign w_nxt_e  = {1'b0, o_nxt};

    // Next position: hold, step, or wrap to zero after the last position.
    always_comb begin
        o_nxt = r_cnt;
        if (i_inc) begin
            o_nxt = w_at_end ? '0 : r_cnt + W'(1);
        end
    end

    assign o_nxt_act = (w_nxt_e < C_ACT);
    assign o_nxt_win = (w_nxt_e >= C_WS) && (w_nxt_e < C_WE);

    // Counter starts on the last position so the first advance lands on 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= LAST;
        end else begin
            r_cnt <= o_nxt;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the pixel-clock domain. Every output is a
// register loaded from the decode of the next position, so x, y, de,
// hsync, vsync and the strobes all describe the same pixel.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COORD_W   = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS0     = H_ACTIVE + H_FP;
    localparam int VS0     = V_ACTIVE + V_FP;

    localparam logic [COORD_W:0] C_HS0 = (COORD_W+1)'(HS0);
    localparam logic [COORD_W:0] C_VS0 = (COORD_W+1)'(VS0);
    localparam logic [COORD_W:0] C_VSE = (COORD_W+1)'(VS0 + V_SYNC);

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_segment
        $error("video_timing_gen: porch and sync lengths must be >= 1");
    end
    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_width
        $error("video_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
    end

    logic [COORD_W-1:0] w_x_nxt;
    logic [COORD_W-1:0] w_y_nxt;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_h_act;
    logic               w_v_act;
    logic               w_h_win;
    logic               w_v_mid;
    logic               w_v_inc;
    logic [COORD_W:0]   w_xe;
    logic [COORD_W:0]   w_ye;
    logic               w_vs_asrt;

    logic               r_de;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_ls;
    logic               r_fs;
    logic [FRAME_W-1:0] r_fc;
    logic               r_first;

    assign w_v_inc = en && w_h_wrap;

    timing_axis #(
        .W(COORD_W), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
        .WIN_START(HS0), .WIN_LEN(H_SYNC)
    ) u_h_axis (
        .i_clk(clk), .i_rst_n(rst_n), .i_inc(en),
        .o_cnt(x), .o_nxt(w_x_nxt), .o_wrap(w_h_wrap),
        .o_nxt_act(w_h_act), .o_nxt_win(w_h_win)
    );

    // The vertical window covers only the lines fully inside vsync; the
    // first and last sync lines are split at HS0 below.
    timing_axis #(
        .W(COORD_W), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
        .WIN_START(VS0 + 1), .WIN_LEN(V_SYNC - 1)
    ) u_v_axis (
        .i_clk(clk), .i_rst_n(rst_n), .i_inc(w_v_inc),
        .o_cnt(y), .o_nxt(w_y_nxt), .o_wrap(w_v_wrap),
        .o_nxt_act(w_v_act), .o_nxt_win(w_v_mid)
    );

    assign w_xe = {1'b0, w_x_nxt};
    assign w_ye = {1'b0, w_y_nxt};

    // vsync edges land on the hsync leading edge of lines VS0 and VS0+V_SYNC.
    assign w_vs_asrt = ((w_ye == C_VS0) && (w_xe >= C_HS0)) ||
                       w_v_mid ||
                       ((w_ye == C_VSE) && (w_xe < C_HS0));

    // Register decodes of the next position; frame_cnt skips the first frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de    <= 1'b0;
            r_hsync <= ~HSYNC_POL;
            r_vsync <= ~VSYNC_POL;
            r_ls    <= 1'b0;
            r_fs    <= 1'b0;
            r_fc    <= '0;
            r_first <= 1'b1;
        end else begin
            r_de    <= w_h_act && w_v_act;
            r_hsync <= w_h_win   ? HSYNC_POL : ~HSYNC_POL;
            r_vsync <= w_vs_asrt ? VSYNC_POL : ~VSYNC_POL;
            r_ls    <= w_h_wrap;
            r_fs    <= w_v_wrap;
            if (w_v_wrap) begin
                if (r_first) begin
                    r_first <= 1'b0;
                end else begin
                    r_fc <= r_fc + FRAME_W'(1);
                end
            end
        end
    end

    assign de          = r_de;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
    assign frame_cnt   = r_fc;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. Three instances: default 640x480 (reset,
// line and mid-frame reset checks), a tiny mode with random en, and a
// reduced mode with FRAME_W=2 for frame-level checks. Drivers push the
// expected outputs into per-instance queues; a monitor pops and compares.
module tb_video_timing_gen;

    typedef struct { int ha, hf, hs, hb, va, vf, vs, vb, fw; bit hp, vp; } cfg_t;
    typedef struct { int x, y, fc; bit first, ls, fs; } st_t;
    typedef struct { int x, y, fc; bit de, hs, vs, ls, fs; } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;

    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic de_a, hs_a, vs_a, ls_a, fs_a;
    logic de_b, hs_b, vs_b, ls_b, fs_b;
    logic de_c, hs_c, vs_c, ls_c, fs_c;
    logic [7:0] fc_a, fc_b;
    logic [1:0] fc_c;

    int total = 0;
    int bad = 0;

    cfg_t cfg[3];
    st_t  st[3];
    out_t qa[$], qb[$], qc[$];

    video_timing_gen dut_a (
        .clk(clk), .rst_n(rst_a), .en(en_a), .x(x_a), .y(y_a), .de(de_a),
        .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a),
        .frame_cnt(fc_a)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .en(en_b), .x(x_b), .y(y_b), .de(de_b),
        .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b),
        .frame_cnt(fc_b)
    );

    video_timing_gen #(
        .H_ACTIVE(40), .H_FP(2), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(5),
        .FRAME_W(2)
    ) dut_c (
        .clk(clk), .rst_n(rst_c), .en(en_c), .x(x_c), .y(y_c), .de(de_c),
        .hsync(hs_c), .vsync(vs_c), .line_start(ls_c), .frame_start(fs_c),
        .frame_cnt(fc_c)
    );

    function automatic st_t rst_state(input cfg_t c);
        st_t s;
        s.x = c.ha + c.hf + c.hs + c.hb - 1;
        s.y = c.va + c.vf + c.vs + c.vb - 1;
        s.fc = 0; s.first = 1'b1; s.ls = 1'b0; s.fs = 1'b0;
        return s;
    endfunction

    function automatic st_t step(input cfg_t c, input st_t s, input bit e);
        st_t n;
        n = s; n.ls = 1'b0; n.fs = 1'b0;
        if (e) begin
            n.x = s.x + 1;
            if (n.x == c.ha + c.hf + c.hs + c.hb) begin
                n.x = 0; n.ls = 1'b1; n.y = s.y + 1;
                if (n.y == c.va + c.vf + c.vs + c.vb) begin
                    n.y = 0; n.fs = 1'b1;
                    if (s.first) n.first = 1'b0;
                    else n.fc = (s.fc + 1) % (1 << c.fw);
                end
            end
        end
        return n;
    endfunction

    function automatic out_t view(input cfg_t c, input st_t s);
        out_t o;
        int hs0, vs0;
        bit ha, va;
        hs0 = c.ha + c.hf;
        vs0 = c.va + c.vf;
        o.x = s.x; o.y = s.y; o.fc = s.fc; o.ls = s.ls; o.fs = s.fs;
        o.de = (s.x < c.ha) && (s.y < c.va);
        ha = (s.x >= hs0) && (s.x < hs0 + c.hs);
        va = (s.y == vs0 && s.x >= hs0) || (s.y > vs0 && s.y < vs0 + c.vs) ||
             (s.y == vs0 + c.vs && s.x < hs0);
        o.hs = ha ? c.hp : !c.hp;
        o.vs = va ? c.vp : !c.vp;
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cmp(input string nm, input out_t e, input int x, input int y,
                       input bit de, input bit hs, input bit vs, input bit ls,
                       input bit fs, input int fc);
        total++;
        if (e.x != x || e.y != y || e.de != de || e.hs != hs || e.vs != vs ||
            e.ls != ls || e.fs != fs || e.fc != fc) begin
            bad++;
            $display("FAIL %s: got x=%0d y=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d want x=%0d y=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                     nm, x, y, de, hs, vs, ls, fs, fc,
                     e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs, e.fc);
        end
    endtask

    // Called at a negedge: sets en and queues the outputs due after the next posedge.
    task automatic drive(input int id, input bit e);
        st[id] = step(cfg[id], st[id], e);
        case (id)
            0: begin en_a = e; qa.push_back(view(cfg[0], st[0])); end
            1: begin en_b = e; qb.push_back(view(cfg[1], st[1])); end
            default: begin en_c = e; qc.push_back(view(cfg[2], st[2])); end
        endcase
    endtask

    // Monitor: compare every queued expectation just after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (qa.size() > 0)
            cmp("sb_a", qa.pop_front(), int'(x_a), int'(y_a), de_a, hs_a, vs_a, ls_a, fs_a, int'(fc_a));
        if (qb.size() > 0)
            cmp("sb_b", qb.pop_front(), int'(x_b), int'(y_b), de_b, hs_b, vs_b, ls_b, fs_b, int'(fc_b));
        if (qc.size() > 0)
            cmp("sb_c", qc.pop_front(), int'(x_c), int'(y_c), de_c, hs_c, vs_c, ls_c, fs_c, int'(fc_c));
    end

    initial begin
        cfg[0] = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, fw:8, hp:1'b0, vp:1'b0};
        cfg[1] = '{ha:4, hf:1, hs:2, hb:1, va:3, vf:1, vs:1, vb:1, fw:8, hp:1'b1, vp:1'b0};
        cfg[2] = '{ha:40, hf:2, hs:6, hb:4, va:30, vf:3, vs:2, vb:5, fw:2, hp:1'b0, vp:1'b0};
        for (int k = 0; k < 3; k++) st[k] = rst_state(cfg[k]);

        @(posedge clk);
        #2;
        chk("a_rst_x", int'(x_a), 799);
        chk("a_rst_y", int'(y_a), 524);
        chk("a_rst_de_hs_vs", int'({de_a, hs_a, vs_a}), 3);
        chk("a_rst_strobes", int'({ls_a, fs_a}), 0);
        chk("a_rst_fc", int'(fc_a), 0);
        chk("b_rst_xy", int'(x_b) * 1000 + int'(y_b), 7005);
        chk("b_rst_hs_vs", int'({hs_b, vs_b}), 1);

        fork
            begin : proc_a
                int de_n, hl_n, hl_x, ls_gap;
                de_n = 0; hl_n = 0; hl_x = -1; ls_gap = -1;
                @(negedge clk);
                rst_a = 1'b1;
                drive(0, 1'b1);
                @(negedge clk);
                chk("a_first_xy", int'(x_a) * 1000 + int'(y_a), 0);
                chk("a_first_strobes", int'({ls_a, fs_a}), 3);
                chk("a_first_de_hs_vs", int'({de_a, hs_a, vs_a}), 7);
                chk("a_first_fc", int'(fc_a), 0);
                for (int i = 0; i <= 800; i++) begin
                    if (i < 800) begin
                        if (de_a) de_n++;
                        if (!hs_a) begin
                            hl_n++;
                            if (hl_x < 0) hl_x = int'(x_a);
                        end
                    end
                    if (ls_a && i > 0 && ls_gap < 0) ls_gap = i;
                    drive(0, 1'b1);
                    @(negedge clk);
                end
                chk("a_de_cycles", de_n, 640);
                chk("a_hsync_cycles", hl_n, 96);
                chk("a_hsync_start_x", hl_x, 656);
                chk("a_line_period", ls_gap, 800);
                for (int j = 0; j < 1899; j++) begin
                    drive(0, 1'b1);
                    @(negedge clk);
                end
                chk("a_mid_xy", int'(x_a) * 1000 + int'(y_a), 300003);
                #2 rst_a = 1'b0;
                #1;
                st[0] = rst_state(cfg[0]);
                chk("a_mid_rst_x", int'(x_a), 799);
                chk("a_mid_rst_y", int'(y_a), 524);
                chk("a_mid_rst_de_hs_vs", int'({de_a, hs_a, vs_a}), 3);
                chk("a_mid_rst_fc", int'(fc_a), 0);
                @(negedge clk);
                rst_a = 1'b1;
                drive(0, 1'b1);
                @(negedge clk);
                chk("a_after_rst_xy", int'(x_a) * 1000 + int'(y_a), 0);
                chk("a_after_rst_fs", int'(fs_a), 1);
                en_a = 1'b0;
            end
            begin : proc_b
                int px, py;
                bit e;
                @(negedge clk);
                rst_b = 1'b1;
                for (int i = 0; i < 600; i++) begin
                    e = 1'($urandom_range(1, 0));
                    px = int'(x_b);
                    py = int'(y_b);
                    drive(1, e);
                    @(negedge clk);
                    if (!e) begin
                        chk("b_hold_xy", int'(x_b) * 1000 + int'(y_b), px * 1000 + py);
                        chk("b_hold_strobes", int'({ls_b, fs_b}), 0);
                    end
                end
                en_b = 1'b0;
            end
            begin : proc_c
                int fsn, last_fs, fall_n, rise_n, de_blank;
                int exp_fc[5];
                bit pv, ph;
                exp_fc = '{0, 1, 2, 3, 0};
                fsn = 0; last_fs = -1; fall_n = 0; rise_n = 0; de_blank = 0;
                pv = 1'b1; ph = 1'b1;
                @(negedge clk);
                rst_c = 1'b1;
                for (int i = 0; i < 8322; i++) begin
                    drive(2, 1'b1);
                    @(negedge clk);
                    if (fs_c) begin
                        if (fsn < 5) chk("c_fc_seq", int'(fc_c), exp_fc[fsn]);
                        fsn++;
                        if (fsn == 2) chk("c_frame_period", i - last_fs, 2080);
                        last_fs = i;
                    end
                    if (pv && !vs_c && fall_n == 0) begin
                        chk("c_vs_assert_xy", int'(x_c) * 1000 + int'(y_c), 42033);
                        chk("c_vs_assert_hs_edge", int'({ph, hs_c}), 2);
                        fall_n++;
                    end
                    if (!pv && vs_c && rise_n == 0) begin
                        chk("c_vs_release_xy", int'(x_c) * 1000 + int'(y_c), 42035);
                        chk("c_vs_release_hs_edge", int'({ph, hs_c}), 2);
                        rise_n++;
                    end
                    if (de_c && int'(y_c) >= 30) de_blank++;
                    pv = vs_c;
                    ph = hs_c;
                end
                chk("c_frame_starts", fsn, 5);
                chk("c_vs_edges", fall_n * 10 + rise_n, 11);
                chk("c_de_in_vblank", de_blank, 0);
                en_c = 1'b0;
            end
        join

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
